sdram_init_refresh_ctrl: RTL

Sequences the SDRAM from power-up to operational state and then shares the command bus between periodic auto-refresh and a single user port. It starts once the startup-delay unit raises `sdram_ready`, issues PRECHARGE ALL, two AUTO REFRESH and LOAD MODE REGISTER, then schedules one AUTO REFRESH per refresh interval. Between refreshes it grants the bus to the user port through a req/gnt/done handshake.

---
 rtl/sdram_init_refresh_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sdram_init_refresh_ctrl.sv
// rtl/sdram_init_refresh_ctrl.sv - SDRAM power-up init sequencer, periodic refresh scheduler and user-port arbiter
// Build option SDRAM_REFRESH_DEBT_EN: 3-bit refresh debt with back-to-back catch-up (default: 1-bit debt).
module sdram_init_refresh_ctrl #(
  parameter real         CLK            = 111857000.0,
  parameter int          T_RP_CYC       = 2,
  parameter int          T_RFC_CYC      = 7,
  parameter int          T_MRD_CYC      = 2,
  parameter int          REFRESH_CYCLES = int'($ceil(7.8e-6 * CLK)),
  parameter logic [10:0] MODE_REG       = 11'h020
) (
  input  logic        clk112M,
  input  logic        reset,
  input  logic        sdram_ready,
  input  logic        user_req,
  input  logic        user_done,
  output logic        user_gnt,
  output logic        init_done,
  output logic        refresh_overrun,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [10:0] sdram_addr
);
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam int TIMER_W = $clog2(REFRESH_CYCLES);
  localparam int WAIT_W  = $clog2(T_RP_CYC + T_RFC_CYC + T_MRD_CYC);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_RP      = WAIT_W'(T_RP_CYC - 1);
  localparam logic [WAIT_W-1:0]  WAIT_RFC     = WAIT_W'(T_RFC_CYC - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MRD     = WAIT_W'(T_MRD_CYC - 1);
`ifdef SDRAM_REFRESH_DEBT_EN
  localparam int DEBT_W = 3;
`else
  localparam int DEBT_W = 1;
`endif
  localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

  typedef enum logic [3:0] {
    S_WAIT_READY, S_CKE_ON, S_PRE, S_REF1, S_REF2, S_LMR,
    S_WAIT, S_IDLE, S_REFRESH, S_USER
  } state_t;

  state_t              state, state_d, ret_state, ret_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic [TIMER_W-1:0]  timer;
  logic [DEBT_W-1:0]   debt;
  logic                abort, expire, issue;
  logic                cke_d, gnt_d, init_d;
  logic [3:0]          cmd_d;
  logic [10:0]         addr_d;

  // Losing sdram_ready anywhere past WAIT_READY tears the sequence down on the next edge.
  assign abort  = (state != S_WAIT_READY) && !sdram_ready;
  assign expire = init_done && (timer == '0);
  assign issue  = (state == S_REFRESH);

  always_ff @(posedge clk112M or posedge reset) begin
    if (reset) begin
      state     <= S_WAIT_READY;
      ret_state <= S_WAIT_READY;
      wait_cnt  <= '0;
    end else begin
      state     <= state_d;
      ret_state <= ret_d;
      wait_cnt  <= wait_d;
    end
  end

  always_comb begin
    state_d = state;
    ret_d   = ret_state;
    wait_d  = wait_cnt;
    if (abort) begin
      state_d = S_WAIT_READY;
      wait_d  = '0;
    end else begin
      case (state)
        S_WAIT_READY: if (sdram_ready) state_d = S_CKE_ON;
        S_CKE_ON:     state_d = S_PRE;
        S_PRE:        begin state_d = S_WAIT; wait_d = WAIT_RP;  ret_d = S_REF1; end
        S_REF1:       begin state_d = S_WAIT; wait_d = WAIT_RFC; ret_d = S_REF2; end
        S_REF2:       begin state_d = S_WAIT; wait_d = WAIT_RFC; ret_d = S_LMR;  end
        S_LMR:        begin state_d = S_WAIT; wait_d = WAIT_MRD; ret_d = S_IDLE; end
        S_REFRESH:    begin state_d = S_WAIT; wait_d = WAIT_RFC; ret_d = S_IDLE; end
        S_WAIT: begin
          if (wait_cnt <= 1) state_d = ret_state;
          else               wait_d  = wait_cnt - 1'b1;
        end
        S_IDLE: begin
          if (debt != '0)    state_d = S_REFRESH;
          else if (user_req) state_d = S_USER;
        end
        S_USER:       if (user_gnt && user_done) state_d = S_IDLE;
        default:      state_d = S_WAIT_READY;
      endcase
    end
  end

  always_comb begin
    cke_d  = 1'b0;
    gnt_d  = 1'b0;
    init_d = 1'b0;
    cmd_d  = CMD_NOP;
    addr_d = '0;
    if (!abort) begin
      cke_d  = (state != S_WAIT_READY);
      gnt_d  = (state == S_USER);
      init_d = init_done || (state == S_IDLE);
      case (state)
        S_PRE:                     begin cmd_d = CMD_PRE; addr_d = 11'h400; end
        S_REF1, S_REF2, S_REFRESH: cmd_d = CMD_REF;
        S_LMR:                     begin cmd_d = CMD_LMR; addr_d = MODE_REG; end
        default:                   cmd_d = CMD_NOP;
      endcase
    end
  end

  always_ff @(posedge clk112M or posedge reset) begin
    if (reset) begin
      sdram_cke <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
      sdram_ba   <= 2'b00;
      sdram_addr <= '0;
      user_gnt   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      sdram_cke <= cke_d;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_d;
      sdram_ba   <= 2'b00;
      sdram_addr <= addr_d;
      user_gnt   <= gnt_d;
      init_done  <= init_d;
    end
  end

  // Expiry and issue in the same cycle cancel; overrun only when an expiry finds debt full.
  always_ff @(posedge clk112M or posedge reset) begin
    if (reset) begin
      timer           <= '0;
      debt            <= '0;
      refresh_overrun <= 1'b0;
    end else if (abort) begin
      timer <= '0;
      debt  <= '0;
    end else begin
      if (state == S_IDLE && !init_done) timer <= TIMER_RELOAD;
      else if (init_done)                timer <= expire ? TIMER_RELOAD : timer - 1'b1;
      if (expire && !issue) begin
        if (debt == DEBT_MAX) refresh_overrun <= 1'b1;
        else                  debt <= debt + 1'b1;
      end else if (issue && !expire) begin
        debt <= debt - 1'b1;
      end
    end
  end
endmodule
